elevator_scheduler: RTL

- Dispatcher between the per-floor request latches (sequence detectors) and the car driver.
- Consumes the 10-bit latched-request vector and the car's current floor.
- Drives the car driver's destination and direction inputs using SCAN (keep travelling while requests lie ahead, else reverse).
- Times door dwell at each stop and issues one-cycle request_clear pulses back to the latches.

---
 rtl/elevator_pkg.sv | 25 ++
 rtl/elevator_scheduler_if.sv | 26 ++
 rtl/elevator_scheduler_nearest_request_finder.sv | 33 +++
 rtl/elevator_scheduler.sv | 126 ++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator dispatcher slice.
package elevator_pkg;

    localparam int   NUM_FLOORS = 10;
    localparam int   FLOOR_W    = 5;
    localparam logic DIR_UP     = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        ARRIVE = 2'd2,
        DOOR   = 2'd3
    } sched_state_t;

    typedef logic [NUM_FLOORS-1:0] floor_vec_t;
    typedef logic [FLOOR_W-1:0]    floor_t;

    // One-hot mask for a floor; an out-of-range floor shifts out to all zeros,
    // so a faulty floor number can never select a latch.
    function automatic floor_vec_t floor_onehot(input floor_t f);
        return floor_vec_t'(1) << f;
    endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Request/car bus between the floor latches, the scheduler and the car driver.
interface elevator_scheduler_if;
    import elevator_pkg::*;

    floor_vec_t  is_requested;
    floor_t      current_floor;
    floor_t      destination;
    logic        direction;
    floor_vec_t  request_clear;
    logic        door_open;
    logic        moving;
    logic [1:0]  sched_state;

    // Environment side: latches and car driver
    modport master (
        output is_requested, current_floor,
        input  destination, direction, request_clear, door_open, moving, sched_state
    );

    // Scheduler side
    modport slave (
        input  is_requested, current_floor,
        output destination, direction, request_clear, door_open, moving, sched_state
    );

endinterface

// File: rtl/elevator_scheduler_nearest_request_finder.sv
// Combinational search for the closest pending request on each side of the car.
module nearest_request_finder
    import elevator_pkg::*;
(
    input  floor_vec_t requests,
    input  floor_t     current_floor,
    output logic       any_above,
    output logic       any_below,
    output floor_t     nearest_above,
    output floor_t     nearest_below
);

    // Scan downward for "above" so the lowest hit wins, upward for "below" so the highest wins
    always_comb begin
        any_above     = 1'b0;
        any_below     = 1'b0;
        nearest_above = '0;
        nearest_below = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (requests[i] && (floor_t'(i) > current_floor)) begin
                any_above     = 1'b1;
                nearest_above = floor_t'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (requests[i] && (floor_t'(i) < current_floor)) begin
                any_below     = 1'b1;
                nearest_below = floor_t'(i);
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN dispatcher: picks the next stop, retargets on the way, times the door
// dwell and pulses the serviced floor's latch clear.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = 100000000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    elevator_scheduler_if.slave  bus
);

    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DOOR_CYCLES - 1);

    sched_state_t      state, state_n;
    floor_t            dest_n;
    logic              dir_n;
    floor_vec_t        clear_n;
    logic [CNT_W-1:0]  dwell, dwell_n;

    logic       any_above, any_below;
    floor_t     nearest_above, nearest_below;
    floor_vec_t here_onehot;
    logic       here_requested;
    logic       clear_pending;
    logic       floor_fault;

    nearest_request_finder u_finder (
        .requests      (bus.is_requested),
        .current_floor (bus.current_floor),
        .any_above     (any_above),
        .any_below     (any_below),
        .nearest_above (nearest_above),
        .nearest_below (nearest_below)
    );

    assign here_onehot    = floor_onehot(bus.current_floor);
    assign here_requested = |(bus.is_requested & here_onehot);
    // The latch still shows the request while our clear pulse is on the bus;
    // ignore it then so one press never yields two pulses.
    assign clear_pending  = |(bus.request_clear & here_onehot);
    assign floor_fault    = (bus.current_floor >= floor_t'(NUM_FLOORS));
    assign bus.sched_state = state;

    // Next-state and next-output decision for the SCAN controller
    always_comb begin
        state_n = state;
        dest_n  = bus.destination;
        dir_n   = bus.direction;
        clear_n = '0;
        dwell_n = dwell;
        if (floor_fault) begin
            state_n = IDLE;
            dest_n  = bus.current_floor;
            dwell_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    dest_n = bus.current_floor;
                    if (here_requested) begin
                        state_n = ARRIVE;
                        clear_n = here_onehot;
                    end else if (any_above && ((bus.direction == DIR_UP) || !any_below)) begin
                        state_n = MOVE;
                        dir_n   = DIR_UP;
                        dest_n  = nearest_above;
                    end else if (any_below) begin
                        state_n = MOVE;
                        dir_n   = DIR_DOWN;
                        dest_n  = nearest_below;
                    end
                end
                MOVE: begin
                    if (bus.current_floor == bus.destination) begin
                        state_n = ARRIVE;
                        clear_n = here_onehot;
                    end else if ((bus.direction == DIR_UP) && any_above &&
                                 (nearest_above < bus.destination)) begin
                        dest_n = nearest_above;
                    end else if ((bus.direction == DIR_DOWN) && any_below &&
                                 (nearest_below > bus.destination)) begin
                        dest_n = nearest_below;
                    end
                end
                ARRIVE: begin
                    state_n = DOOR;
                    dwell_n = DWELL_LOAD;
                end
                DOOR: begin
                    if (here_requested && !clear_pending) begin
                        clear_n = here_onehot;
                        dwell_n = DWELL_LOAD;
                    end else if (dwell == '0) begin
                        state_n = IDLE;
                    end else begin
                        dwell_n = dwell - 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, dwell counter and all registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state             <= IDLE;
            dwell             <= '0;
            bus.destination   <= '0;
            bus.direction     <= DIR_UP;
            bus.request_clear <= '0;
            bus.door_open     <= 1'b0;
            bus.moving        <= 1'b0;
        end else begin
            state             <= state_n;
            dwell             <= dwell_n;
            bus.destination   <= dest_n;
            bus.direction     <= dir_n;
            bus.request_clear <= clear_n;
            bus.door_open     <= (state_n == ARRIVE) || (state_n == DOOR);
            bus.moving        <= (state_n == MOVE);
        end
    end

endmodule
